// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical memory port between I-cache and D-cache line requests,
// alternating grants under contention and holding each transaction's request in registers.
module pmem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_pmem_read,
  input  logic [31:0]  i_pmem_address,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [31:0]  d_pmem_address,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} state_t;
  state_t state_q, state_d;
  logic last_d_q, last_d_d;
  logic mem_read_q, mem_read_d;
  logic mem_write_q, mem_write_d;
  logic [31:0] addr_q, addr_d;
  logic [255:0] wdata_q, wdata_d;
  logic grant_d;
  // D wins when it is alone or when the previous grant went to I
  assign grant_d = (d_pmem_read | d_pmem_write) & (~i_pmem_read | ~last_d_q);
  always_comb begin
    state_d = state_q;
    last_d_d = last_d_q;
    mem_read_d = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = SERVE_D;
          last_d_d = 1'b1;
          addr_d = d_pmem_address;
          mem_write_d = d_pmem_write;
          mem_read_d = ~d_pmem_write;
          wdata_d = d_pmem_write ? d_pmem_wdata : wdata_q;
        end else if (i_pmem_read) begin
          state_d = SERVE_I;
          last_d_d = 1'b0;
          addr_d = i_pmem_address;
          mem_read_d = 1'b1;
          mem_write_d = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_d = RECOVER;
          mem_read_d = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_d_q <= 1'b0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_d_q <= last_d_d;
      mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign mem_read = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_address = addr_q;
  assign mem_wdata = wdata_q;
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  assign i_pmem_resp = rst_n & mem_resp & (state_q == SERVE_I);
  assign d_pmem_resp = rst_n & mem_resp & (state_q == SERVE_D);
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed checks of pmem_arbiter grant order, hold registers, resp timing and reset.
module tb_pmem_arbiter;
  logic clk = 0, rst_n = 0;
  logic i_pmem_read = 0, d_pmem_read = 0, d_pmem_write = 0, mem_resp = 0;
  logic [31:0] i_pmem_address = 0, d_pmem_address = 0;
  logic [255:0] d_pmem_wdata = 0, mem_rdata = 0;
  logic [255:0] i_pmem_rdata, d_pmem_rdata, mem_wdata;
  logic i_pmem_resp, d_pmem_resp, mem_read, mem_write;
  logic [31:0] mem_address;
  int total = 0, bad = 0;
  localparam logic [255:0] AA = {32{8'hAA}};
  localparam logic [255:0] P55 = {32{8'h55}};
  pmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    @(negedge clk);
  endtask
  task automatic chk1(input string tag, input logic o, input logic e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, o, e);
    end
  endtask
  task automatic chka(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask
  task automatic chkw(input string tag, input logic [255:0] o, input logic [255:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask
  initial begin
    // reset, with a stray mem_resp that must not leak out
    mem_resp = 1;
    tick(); tick();
    settle();
    chk1("rst_read", mem_read, 0); chk1("rst_write", mem_write, 0);
    chka("rst_addr", mem_address, 0); chkw("rst_wdata", mem_wdata, 0);
    chk1("rst_iresp", i_pmem_resp, 0); chk1("rst_dresp", d_pmem_resp, 0);
    tick(); rst_n = 1; mem_resp = 0;
    // single I read
    tick(); i_pmem_read = 1; i_pmem_address = 32'h0000_1000;
    settle(); chk1("i_n_read", mem_read, 0);
    tick(); settle();
    chk1("i_n1_read", mem_read, 1); chk1("i_n1_write", mem_write, 0);
    chka("i_addr", mem_address, 32'h0000_1000);
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      chk1("i_wait_read", mem_read, 1); chk1("i_wait_resp", i_pmem_resp, 0);
    end
    tick(); mem_resp = 1; mem_rdata = AA;
    settle();
    chk1("i_resp", i_pmem_resp, 1); chk1("i_dresp0", d_pmem_resp, 0);
    chkw("i_rdata", i_pmem_rdata, AA);
    tick(); mem_resp = 0; i_pmem_read = 0;
    settle(); chk1("i_recover_read", mem_read, 0); chk1("i_resp_once", i_pmem_resp, 0);
    tick();
    // D write-back with address/data churn mid-transaction
    tick(); d_pmem_write = 1; d_pmem_address = 32'h0000_2020; d_pmem_wdata = P55;
    tick(); settle();
    chk1("d_write", mem_write, 1); chk1("d_read0", mem_read, 0);
    chka("d_addr", mem_address, 32'h0000_2020); chkw("d_wdata", mem_wdata, P55);
    d_pmem_address = 32'hDEAD_BEE0; d_pmem_wdata = '0;
    tick(); settle();
    chka("churn_addr", mem_address, 32'h0000_2020); chkw("churn_wdata", mem_wdata, P55);
    chk1("churn_write", mem_write, 1);
    tick(); mem_resp = 1;
    settle(); chk1("d_resp", d_pmem_resp, 1); chk1("d_iresp0", i_pmem_resp, 0);
    tick(); mem_resp = 0; d_pmem_write = 0;
    settle(); chk1("d_resp_once", d_pmem_resp, 0); chk1("d_recover_write", mem_write, 0);
    tick();
    // contention right after reset: D, then I, then D
    rst_n = 0; tick(); rst_n = 1;
    i_pmem_read = 1; i_pmem_address = 32'h0000_3000;
    d_pmem_read = 1; d_pmem_address = 32'h0000_4040;
    tick(); settle();
    chka("c1_addr", mem_address, 32'h0000_4040); chk1("c1_read", mem_read, 1);
    tick(); mem_resp = 1;
    settle(); chk1("c1_dresp", d_pmem_resp, 1); chk1("c1_iresp", i_pmem_resp, 0);
    tick(); mem_resp = 0; d_pmem_address = 32'h0000_5050;
    settle(); chk1("c1_recover", mem_read, 0);
    tick(); settle(); chk1("c_idle_read", mem_read, 0);
    tick(); settle();
    chka("c2_addr", mem_address, 32'h0000_3000); chk1("c2_read", mem_read, 1);
    tick(); mem_resp = 1;
    settle(); chk1("c2_iresp", i_pmem_resp, 1); chk1("c2_dresp", d_pmem_resp, 0);
    tick(); mem_resp = 0;
    tick(); tick(); settle();
    chka("c3_addr", mem_address, 32'h0000_5050); chk1("c3_read", mem_read, 1);
    tick(); mem_resp = 1;
    settle(); chk1("c3_dresp", d_pmem_resp, 1);
    tick(); mem_resp = 0; i_pmem_read = 0; d_pmem_read = 0;
    tick();
    // spurious response in IDLE
    tick(); mem_resp = 1;
    settle(); chk1("sp_iresp", i_pmem_resp, 0); chk1("sp_dresp", d_pmem_resp, 0);
    tick(); mem_resp = 0;
    settle(); chka("sp_state", 32'(dut.state_q), 32'd0); chk1("sp_read", mem_read, 0);
    // reset mid-transaction
    tick(); i_pmem_read = 1; i_pmem_address = 32'h0000_6000;
    tick(); settle(); chk1("r_read", mem_read, 1);
    tick(); rst_n = 0; mem_resp = 1;
    settle(); chk1("r_iresp", i_pmem_resp, 0);
    tick(); rst_n = 1; mem_resp = 0; i_pmem_read = 0;
    settle();
    chk1("r_read0", mem_read, 0); chka("r_state", 32'(dut.state_q), 32'd0);
    chka("r_addr0", mem_address, 0);
    tick(); i_pmem_read = 1; i_pmem_address = 32'h0000_7000;
    tick(); settle(); chka("r2_addr", mem_address, 32'h0000_7000); chk1("r2_read", mem_read, 1);
    tick(); mem_resp = 1; mem_rdata = P55;
    settle(); chk1("r2_iresp", i_pmem_resp, 1); chkw("r2_rdata", i_pmem_rdata, P55);
    tick(); mem_resp = 0; i_pmem_read = 0;
    tick();
    // D read and write together latch a write
    tick(); d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 32'h0000_8080; d_pmem_wdata = AA;
    tick(); settle();
    chk1("rw_write", mem_write, 1); chk1("rw_read", mem_read, 0); chkw("rw_wdata", mem_wdata, AA);
    tick(); mem_resp = 1;
    settle(); chk1("rw_dresp", d_pmem_resp, 1);
    tick(); mem_resp = 0; d_pmem_read = 0; d_pmem_write = 0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- i_pmem_read  in  1  I-cache line-fill request.
- i_pmem_address  in  32  I-cache line address.
- i_pmem_rdata  out  256  line data returned to I-cache.
- i_pmem_resp  out  1  I-cache completion pulse.
- d_pmem_read  in  1  D-cache line-fill request.
- d_pmem_write  in  1  D-cache write-back request.
- d_pmem_address  in  32  D-cache line address.
- d_pmem_wdata  in  256  D-cache write-back data.
- d_pmem_rdata  out  256  line data returned to D-cache.
- d_pmem_resp  out  1  D-cache completion pulse.
- mem_read  out  1  physical memory read strobe.
- mem_write  out  1  physical memory write strobe.
- mem_address  out  32  physical memory address.
- mem_wdata  out  256  physical memory write data.
- mem_rdata  in  256  physical memory read data.
- mem_resp  in  1  physical memory completion, one-cycle pulse.

Function
REQ-002 The block SHALL implement states IDLE, SERVE_I, SERVE_D and RECOVER, held in a state register.
REQ-003 In IDLE with only i_pmem_read high, the block SHALL enter SERVE_I on the next edge.
REQ-004 In IDLE with only d_pmem_read or d_pmem_write high, the block SHALL enter SERVE_D on the next edge.
REQ-005 In IDLE with both sides requesting, the block SHALL grant the side not named by the last_grant register; last_grant updates on every grant.
REQ-006 On the granting edge, the block SHALL latch the winner's address, op (read or write) and, for D writes, wdata into hold registers.
- mem_address, mem_wdata, mem_read and mem_write SHALL come from registers only.
- Outputs SHALL remain stable for the whole transaction regardless of requester input changes.
REQ-007 If d_pmem_read and d_pmem_write are both high at grant, the block SHALL latch a write.
REQ-008 mem_read SHALL be 1 in SERVE_I, and 1 in SERVE_D with a latched read; mem_write SHALL be 1 only in SERVE_D with a latched write; both SHALL be 0 in IDLE and RECOVER.
REQ-009 In SERVE_x, while mem_resp is 0, the block SHALL hold state; there is no timeout.
REQ-010 In SERVE_x with mem_resp=1, the block SHALL drive x_pmem_resp=1 combinationally in the same cycle and enter RECOVER on the next edge.
REQ-011 x_pmem_rdata SHALL equal mem_rdata at all times; the other side's resp SHALL be 0.
REQ-012 RECOVER SHALL last exactly one cycle, ignore all requests, and return to IDLE. Minimum issue-to-issue gap is therefore 3 cycles: the resp cycle, RECOVER and IDLE.
REQ-013 Latency: a request first high in IDLE at cycle N SHALL see the mem strobe high at cycle N+1; resp SHALL reach the requester in the same cycle as mem_resp.
REQ-014 If a requester drops its request mid-transaction, the transaction SHALL complete, and x_pmem_resp SHALL still pulse.
REQ-015 A mem_resp arriving in IDLE or RECOVER SHALL be ignored: no resp output, no state change.
REQ-016 i_pmem_resp and d_pmem_resp SHALL never be 1 in the same cycle.

Reset
REQ-017 With rst_n=0 at a posedge, the block SHALL set:
- state to IDLE;
- last_grant to I;
- mem_read, mem_write, mem_address and mem_wdata to 0.
REQ-018 Reset SHALL abort any in-flight transaction with no resp pulse; strobes SHALL be 0 from the cycle after the reset edge.
REQ-019 i_pmem_resp and d_pmem_resp SHALL be 0 while in reset.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single I read: i_pmem_read=1, address 0x0000_1000, mem_resp after 5 cycles with rdata=0xAA..AA -> mem_read=1 at N+1, mem_address=0x0000_1000, i_pmem_resp 1 cycle with rdata 0xAA..AA, d_pmem_resp=0.
- D write-back: d_pmem_write=1, address 0x0000_2020, wdata=0x55..55 -> mem_write=1, mem_read=0, mem_wdata=0x55..55 held until mem_resp, d_pmem_resp pulses once.
- Contention after reset: I and D both request at cycle N -> D served first. After RECOVER, I is served; then both request again -> D served.
- Input churn: change d_pmem_address to 0xDEAD_BEE0 during SERVE_D -> mem_address unchanged until completion.
- Spurious response: mem_resp=1 in IDLE -> no resp outputs, state stays IDLE.
- Reset mid-transaction: rst_n=0 during SERVE_I -> next cycle mem_read=0 and state IDLE, no i_pmem_resp; later requests served normally.
